// File: rtl/btn_evt_pkg.sv
// rtl/btn_evt_pkg.sv - register bit offsets shared by the button event block
//
// Purpose: bit positions of the single status/control word.
//   PRESS_LSB : first sticky press flag bit
//   REL_LSB   : first sticky release flag bit
//   IRQEN_BIT : interrupt enable bit
package btn_evt_pkg;

    localparam int PRESS_LSB = 8;
    localparam int REL_LSB   = 16;
    localparam int IRQEN_BIT = 24;

endpackage

// File: rtl/btn_evt_db_cell.sv
// rtl/btn_evt_db_cell.sv - one button's debounce counter, level and edge pulses
//
// Purpose: accepts a new level only after DB_CYCLES consecutive cycles of
// disagreement between btn_in and the current debounced level.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   btn_in   : synchronised raw button level
//   db       : debounced level
//   rise     : high in the cycle whose clock edge takes db 0->1
//   fall     : high in the cycle whose clock edge takes db 1->0
module btn_db_cell #(
    parameter int DB_CYCLES = 50000,
    parameter int CNT_W     = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic db,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             accept;

    // Disagreement has lasted DB_CYCLES-1 edges already: this edge flips db.
    assign accept = (btn_in != db) && (cnt == CNT_LAST);

    // Combinational so that the top can set its flags on the same edge that
    // updates db.
    assign rise = accept &  btn_in;
    assign fall = accept & ~btn_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db  <= 1'b0;
            cnt <= '0;
        end else if (btn_in == db) begin
            cnt <= '0;
        end else if (accept) begin
            db  <= btn_in;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/btn_evt.sv
// rtl/btn_evt.sv - debounced buttons with sticky press/release flags and irq
//
// Purpose: debounces NBTN synchronised buttons, records press/release events
// in write-1-to-clear flags and raises a level interrupt on pending presses.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   stb, we   : IO slot select, 1 = write
//   data_in   : write data (W1C flags, irq_en load)
//   data_out  : read data, 0 unless stb & ~we
//   ack       : equals stb
//   btn_in    : synchronised buttons, active-high
//   btn_db    : debounced levels
//   irq       : irq_en & any press flag
module btn_evt
    import btn_evt_pkg::*;
#(
    parameter int NBTN      = 4,
    parameter int DB_CYCLES = 50000,
    parameter int CNT_W     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stb,
    input  logic            we,
    input  logic [31:0]     data_in,
    output logic [31:0]     data_out,
    output logic            ack,
    input  logic [NBTN-1:0] btn_in,
    output logic [NBTN-1:0] btn_db,
    output logic            irq
);

    logic [NBTN-1:0] rise;
    logic [NBTN-1:0] fall;
    logic [NBTN-1:0] press_flag;
    logic [NBTN-1:0] rel_flag;
    logic            irq_en;
    logic            wr;
    logic [NBTN-1:0] press_clr;
    logic [NBTN-1:0] rel_clr;
    logic            unused_data;

    for (genvar i = 0; i < NBTN; i++) begin : g_cell
        btn_db_cell #(
            .DB_CYCLES(DB_CYCLES),
            .CNT_W    (CNT_W)
        ) u_cell (
            .clk   (clk),
            .rst   (rst),
            .btn_in(btn_in[i]),
            .db    (btn_db[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

    assign wr        = stb & we;
    assign press_clr = wr ? data_in[PRESS_LSB +: NBTN] : '0;
    assign rel_clr   = wr ? data_in[REL_LSB +: NBTN]   : '0;

    // Only a few write bits are meaningful; the rest are ignored.
    assign unused_data = &{1'b0, data_in};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press_flag <= '0;
            rel_flag   <= '0;
            irq_en     <= 1'b0;
        end else begin
            // Set is ORed in after the clear so a same-cycle edge wins.
            press_flag <= (press_flag & ~press_clr) | rise;
            rel_flag   <= (rel_flag   & ~rel_clr)   | fall;
            if (wr) begin
                irq_en <= data_in[IRQEN_BIT];
            end
        end
    end

    assign ack = stb;
    assign irq = irq_en & (|press_flag);

    always_comb begin
        data_out = '0;
        if (stb && !we) begin
            data_out[NBTN-1:0]             = btn_db;
            data_out[PRESS_LSB +: NBTN]    = press_flag;
            data_out[REL_LSB +: NBTN]      = rel_flag;
            data_out[IRQEN_BIT]            = irq_en;
        end
    end

endmodule

// File: tb/tb_btn_evt.sv
// tb/tb_btn_evt.sv - self-checking bench for btn_evt
module tb_btn_evt;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb;
    logic        we;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ack;
    logic [3:0]  btn_in;
    logic [3:0]  btn_db;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    btn_evt #(
        .NBTN     (4),
        .DB_CYCLES(8),
        .CNT_W    (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .stb     (stb),
        .we      (we),
        .data_in (data_in),
        .data_out(data_out),
        .ack     (ack),
        .btn_in  (btn_in),
        .btn_db  (btn_db),
        .irq     (irq)
    );

    typedef struct {
        string       name;
        logic [3:0]  btn;
        int          cyc;
        logic [3:0]  exp_db;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input string name, input logic [31:0] exp);
        stb = 1'b1;
        we  = 1'b0;
        #1;
        chk({name, "_rd"}, data_out, exp);
        chk({name, "_ack"}, {31'b0, ack}, 32'd1);
        stb = 1'b0;
        #1;
    endtask

    task automatic wr(input logic [31:0] d);
        stb     = 1'b1;
        we      = 1'b1;
        data_in = d;
        cycles(1);
        stb     = 1'b0;
        we      = 1'b0;
        data_in = '0;
    endtask

    initial begin
        rst = 1'b1; stb = 1'b0; we = 1'b0; data_in = '0; btn_in = '0;

        // 1. reset held with toggling buttons
        for (int i = 0; i < 4; i++) begin
            btn_in = (i % 2 == 0) ? 4'hF : 4'h0;
            cycles(1);
            chk("rst_db", {28'b0, btn_db}, 32'h0);
            chk("rst_irq", {31'b0, irq}, 32'h0);
            rd("rst", 32'h0);
        end
        btn_in = '0;
        cycles(1);
        rst = 1'b0;

        // 2. glitch, 3. clean press with latency boundary
        vecs[0] = '{"glitch_hi",  4'b0001, 5, 4'b0000, 32'h0000_0000};
        vecs[1] = '{"glitch_lo",  4'b0000, 10, 4'b0000, 32'h0000_0000};
        vecs[2] = '{"press2_m1",  4'b0100, 7, 4'b0000, 32'h0000_0000};
        vecs[3] = '{"press2_lat", 4'b0100, 1, 4'b0100, 32'h0000_0404};
        for (int i = 0; i < 4; i++) begin
            btn_in = vecs[i].btn;
            cycles(vecs[i].cyc);
            chk({vecs[i].name, "_db"}, {28'b0, btn_db}, {28'b0, vecs[i].exp_db});
            rd(vecs[i].name, vecs[i].exp_rd);
        end

        // 4. irq enable, press, clear
        wr(32'h0000_0400);
        rd("clr_p2", 32'h0000_0004);
        wr(32'h0100_0000);
        chk("irq_en_nopress", {31'b0, irq}, 32'h0);
        rd("irq_en", 32'h0100_0004);
        btn_in = 4'b0110;
        cycles(7);
        chk("irq_before", {31'b0, irq}, 32'h0);
        cycles(1);
        chk("irq_press1", {31'b0, irq}, 32'h1);
        rd("press1", 32'h0100_0206);
        wr(32'h0100_0200);
        chk("irq_cleared", {31'b0, irq}, 32'h0);
        rd("press1_clr", 32'h0100_0006);

        // 5. release edge coincides with W1C of that rel flag
        btn_in = 4'b0100;
        cycles(7);
        rd("rel_pending", 32'h0100_0006);
        wr(32'h0102_0000);
        rd("rel_setwins", 32'h0102_0004);
        wr(32'h0102_0000);
        rd("rel_clr", 32'h0100_0004);

        // 6. simultaneous presses on buttons 0 and 3
        btn_in = 4'b1101;
        cycles(8);
        chk("multi_irq", {31'b0, irq}, 32'h1);
        rd("multi", 32'h0100_090D);
        wr(32'h0100_0100);
        rd("multi_clr0", 32'h0100_080D);

        // async reset mid-debounce, no clock edge needed
        btn_in = 4'b1111;
        cycles(3);
        #2;
        rst = 1'b1;
        #1;
        chk("async_db", {28'b0, btn_db}, 32'h0);
        chk("async_irq", {31'b0, irq}, 32'h0);
        rd("async", 32'h0);
        cycles(1);
        rst = 1'b0;
        cycles(7);
        rd("post_rst_m1", 32'h0000_0000);
        cycles(1);
        rd("post_rst", 32'h0000_0F0F);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
